// File: rtl/aes_encipher_ctrl.sv
// Round sequencer for the word-serial AES encipher datapath.
// Optional key-expansion S-box sharing: define AES_ENC_CTRL_SBOX_SHARE_EN.
module aes_encipher_ctrl #(
  parameter logic [3:0] AES128_ROUNDS = 4'ha,
  parameter logic [3:0] AES192_ROUNDS = 4'hc,
  parameter logic [3:0] AES256_ROUNDS = 4'he
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       next,
  input  logic [1:0] keylen,
`ifdef AES_ENC_CTRL_SBOX_SHARE_EN
  input  logic       key_sbox_req,
  output logic       key_sbox_gnt,
`endif
  output logic [3:0] round,
  output logic [1:0] round_type,
  output logic [1:0] sword_sel,
  output logic [3:0] word_we,
  output logic       block_we,
  output logic       ready,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    SBOX,
    ROUND
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] round_ctr_q, round_ctr_d;
  logic [1:0] word_ctr_q, word_ctr_d;
  logic [3:0] limit_q, limit_d;
  logic [3:0] round_q, round_d;
  logic [1:0] round_type_q, round_type_d;
  logic [1:0] sword_sel_q, sword_sel_d;
  logic [3:0] word_we_q, word_we_d;
  logic       block_we_q, block_we_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic [3:0] keylen_rounds;

  always_comb begin
    unique case (keylen)
      2'd1:    keylen_rounds = AES192_ROUNDS;
      2'd2:    keylen_rounds = AES256_ROUNDS;
      default: keylen_rounds = AES128_ROUNDS;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    round_ctr_d = round_ctr_q;
    word_ctr_d  = word_ctr_q;
    limit_d     = limit_q;
    unique case (state_q)
      IDLE: begin
        if (next) begin
          limit_d     = keylen_rounds;
          round_ctr_d = 4'd0;
          word_ctr_d  = 2'd0;
          state_d     = INIT;
        end
      end
      INIT: begin
        round_ctr_d = 4'd1;
        word_ctr_d  = 2'd0;
        state_d     = SBOX;
      end
      SBOX: begin
        word_ctr_d = word_ctr_q + 2'd1;
        if (word_ctr_q == 2'd3) state_d = ROUND;
      end
      ROUND: begin
        if (round_ctr_q < limit_q) begin
          round_ctr_d = round_ctr_q + 4'd1;
          state_d     = SBOX;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it.
  always_comb begin
    round_d      = round_q;
    round_type_d = 2'd3;
    sword_sel_d  = 2'd0;
    word_we_d    = 4'd0;
    block_we_d   = 1'b0;
    ready_d      = 1'b0;
    done_d       = 1'b0;
    unique case (state_d)
      IDLE: begin
        ready_d = 1'b1;
        done_d  = (state_q == ROUND);
      end
      INIT: begin
        round_d      = 4'd0;
        round_type_d = 2'd0;
        block_we_d   = 1'b1;
      end
      SBOX: begin
        round_d     = round_ctr_d;
        sword_sel_d = word_ctr_d;
        word_we_d   = 4'b0001 << word_ctr_d;
      end
      ROUND: begin
        round_d      = round_ctr_d;
        block_we_d   = 1'b1;
        round_type_d = (round_ctr_d < limit_d) ? 2'd1 : 2'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      round_ctr_q  <= 4'd0;
      word_ctr_q   <= 2'd0;
      limit_q      <= AES128_ROUNDS;
      round_q      <= 4'd0;
      round_type_q <= 2'd3;
      sword_sel_q  <= 2'd0;
      word_we_q    <= 4'd0;
      block_we_q   <= 1'b0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_ctr_q  <= round_ctr_d;
      word_ctr_q   <= word_ctr_d;
      limit_q      <= limit_d;
      round_q      <= round_d;
      round_type_q <= round_type_d;
      sword_sel_q  <= sword_sel_d;
      word_we_q    <= word_we_d;
      block_we_q   <= block_we_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
    end
  end

`ifdef AES_ENC_CTRL_SBOX_SHARE_EN
  assign key_sbox_gnt = key_sbox_req & ~reset & (state_q != SBOX);
`endif

  assign round      = round_q;
  assign round_type = round_type_q;
  assign sword_sel  = sword_sel_q;
  assign word_we    = word_we_q;
  assign block_we   = block_we_q;
  assign ready      = ready_q;
  assign done       = done_q;

endmodule

// File: doc/aes_encipher_ctrl.md
Name: aes_encipher_ctrl

Overview:
- Sequencing controller for the AES encipher round datapath.
- Accepts a start pulse and runs the init, main and final round sequence for the selected key length.
- Drives round index, round type, S-box word select and block-register write enables.
- Sits between the aes core control FSM and the word-serial encipher round datapath, which uses one 32-bit S-box for 4 cycles per round.

Parameters:
- AES128_ROUNDS, 4'ha, number of rounds for 128-bit keys.
- AES192_ROUNDS, 4'hc, number of rounds for 192-bit keys.
- AES256_ROUNDS, 4'he, number of rounds for 256-bit keys.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- next  in  1  start pulse; accepted only while ready=1.
- keylen  in  2  0=128, 1=192, 2=256, 3 treated as 128; sampled when next is accepted.
- round  out  4  round index to the key memory and datapath.
- round_type  out  2  0=INIT, 1=MAIN, 2=FINAL, 3=NONE (datapath holds).
- sword_sel  out  2  S-box word mux select (column 0..3).
- word_we  out  4  one-hot write enable for block word 0..3 during S-box phase.
- block_we  out  1  full 128-bit block register write enable.
- ready  out  1  idle and result valid.
- done  out  1  single-cycle pulse when the sequence completes.

Behaviour:
- All outputs are registered, driven from the FSM state plus a 4-bit round counter and a 2-bit word counter.
- Reset values: ready=1, done=0, round=0, round_type=3, sword_sel=0, word_we=0, block_we=0, state=IDLE.
- States: IDLE, INIT, SBOX, ROUND.
- IDLE:
  - ready=1, round_type=3.
  - next=1 latches the round limit N from keylen, clears both counters, drops ready, and moves to INIT.
- INIT, one cycle:
  - round=0, round_type=0, block_we=1.
  - Then round_ctr=1 and the FSM moves to SBOX.
- SBOX, four cycles:
  - sword_sel = word_ctr.
  - word_we = one-hot(word_ctr), so words 0,1,2,3 are written in that order.
  - round = round_ctr, round_type=3.
  - word_ctr wraps 3->0, and the wrap moves the FSM to ROUND.
- ROUND, one cycle:
  - block_we=1, round = round_ctr.
  - round_type=1 if round_ctr<N, else 2.
  - If round_ctr<N: round_ctr increments and the FSM returns to SBOX.
  - Otherwise the FSM goes to IDLE, with done=1 and ready=1 in the first IDLE cycle.
- Latency: ready is low for exactly 1+5N cycles (51 for 128, 61 for 192, 71 for 256).
- Every other cycle: block_we and word_we are 0, done is 0.
- At most one of block_we and word_we is ever active in a cycle.
- next while ready=0 is ignored; there is no queueing.
- keylen changes mid-run have no effect.
- next in the same cycle as done/ready reasserting starts a new run immediately.
- reset mid-operation forces the reset values on the next edge, and any partial result is abandoned.
- round_ctr never exceeds N and never wraps.

Optional Feature:
- Macro: AES_ENC_CTRL_SBOX_SHARE_EN.
- When defined:
  - Adds input key_sbox_req (1) and output key_sbox_gnt (1).
  - key_sbox_gnt = key_sbox_req AND state!=SBOX, computed combinationally.
  - This lets the key expansion unit share the S-box outside the SBOX phase.
  - The encipher sequence is never stalled.
  - key_sbox_gnt is 0 during reset.
- When not defined: the ports are absent and behaviour is otherwise identical.

Test Plan:
- Reset then keylen=0, next pulse -> INIT at round 0, then rounds 1..9 with round_type=1 and round 10 with round_type=2; ready low 51 cycles; done pulses once; word_we sequence 1,2,4,8 before every block_we.
- keylen=2, then keylen=1, then keylen=3 -> ready low 71, 61 and 51 cycles; final round value 14, 12 and 10 respectively.
- next re-pulsed at cycles 5 and 30 of a 128-bit run -> ignored; total latency still 51; exactly one done.
- reset asserted at cycle 20 of a run -> next cycle shows ready=1, round_type=3, all enables 0; a new next then completes normally in 51 cycles.
- next held high continuously with keylen=0 -> back-to-back runs; a new INIT starts the cycle done is high; done period is 52 cycles.
- With AES_ENC_CTRL_SBOX_SHARE_EN and key_sbox_req=1 held -> key_sbox_gnt is 0 exactly during the 4-cycle SBOX phases and 1 otherwise; encipher latency remains 51.
